rll_keyed_pipe: RTL

RLL_KEYED_PIPE -- requirements
Module: rll_keyed_pipe

---
 rtl/rll_keyed_pipe.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rll_keyed_pipe.sv
// Keyed XOR/XNOR data pipeline with a serially loaded key register.
// Define RLL_KEY_PARITY_EN to require a trailing even-parity bit on each key load.
module rll_keyed_pipe #(
   parameter int unsigned      KEY_W    = 32,
   parameter int unsigned      DATA_W   = 32,
   parameter int unsigned      STAGES   = 2,
   parameter logic [KEY_W-1:0] INV_MASK = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_start,
   input  logic              key_valid,
   input  logic              key_bit,
   output logic              key_loaded,
   output logic              key_error,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   localparam int unsigned CNT_W = $clog2(KEY_W + 1) + 1;

   logic [KEY_W-1:0] key_q, key_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             key_loaded_q, key_loaded_d;
   logic             key_err;
   logic             accept;

`ifdef RLL_KEY_PARITY_EN
   logic key_error_q, key_error_d;
   logic par_q, par_d;
   assign key_err = key_error_q;
`else
   assign key_err = 1'b0;
`endif

   assign key_loaded = key_loaded_q;
   assign key_error  = key_err;

   always_comb begin
      key_d        = key_q;
      cnt_d        = cnt_q;
      key_loaded_d = key_loaded_q;
`ifdef RLL_KEY_PARITY_EN
      key_error_d  = key_error_q;
      par_d        = par_q;
`endif
      // A failed load also locks out further bits until the next key_start.
      accept = key_valid && !key_loaded_q && !key_err && !key_start;
      if (key_start) begin
         cnt_d        = '0;
         key_loaded_d = 1'b0;
`ifdef RLL_KEY_PARITY_EN
         key_error_d  = 1'b0;
         par_d        = 1'b0;
`endif
      end else if (accept) begin
         for (int unsigned i = 0; i < KEY_W; i++) begin
            if (cnt_q == CNT_W'(i)) key_d[i] = key_bit;
         end
         cnt_d = cnt_q + CNT_W'(1);
`ifdef RLL_KEY_PARITY_EN
         if (cnt_q == CNT_W'(KEY_W)) begin
            cnt_d = '0;
            if (par_q ^ key_bit) key_error_d  = 1'b1;
            else                 key_loaded_d = 1'b1;
         end else begin
            par_d = par_q ^ key_bit;
         end
`else
         if (cnt_q == CNT_W'(KEY_W - 1)) begin
            cnt_d        = '0;
            key_loaded_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_q        <= '0;
         cnt_q        <= '0;
         key_loaded_q <= 1'b0;
`ifdef RLL_KEY_PARITY_EN
         key_error_q  <= 1'b0;
         par_q        <= 1'b0;
`endif
      end else begin
         key_q        <= key_d;
         cnt_q        <= cnt_d;
         key_loaded_q <= key_loaded_d;
`ifdef RLL_KEY_PARITY_EN
         key_error_q  <= key_error_d;
         par_q        <= par_d;
`endif
      end
   end

   // Key and inversion mask repeat across the data width.
   logic [DATA_W-1:0] mask_ext;
   always_comb begin
      mask_ext = '0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         mask_ext[i] = key_q[i % KEY_W] ^ INV_MASK[i % KEY_W];
      end
   end

   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] take;
   logic [STAGES-1:0] prev_vld;
   logic [DATA_W-1:0] data_q    [STAGES];
   logic [DATA_W-1:0] prev_data [STAGES];
   logic              in_fire;

   // A stage can accept when it, or any stage downstream of it, has a hole, or the output drains.
   always_comb begin
      logic tail_full;
      tail_full = 1'b1;
      take      = '0;
      for (int s = STAGES - 1; s >= 0; s--) begin
         tail_full = tail_full & vld_q[s];
         take[s]   = out_ready | ~tail_full;
      end
   end

   assign in_ready = key_loaded_q & take[0];
   assign in_fire  = in_valid & in_ready;

   always_comb begin
      prev_vld     = '0;
      prev_vld[0]  = in_fire;
      prev_data[0] = in_data ^ mask_ext;
      for (int s = 1; s < STAGES; s++) begin
         prev_vld[s]  = vld_q[s-1];
         prev_data[s] = data_q[s-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         for (int s = 0; s < STAGES; s++) data_q[s] <= '0;
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (take[s]) begin
               vld_q[s] <= prev_vld[s];
               if (prev_vld[s]) data_q[s] <= prev_data[s];
            end
         end
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign out_data  = data_q[STAGES-1];

endmodule
